rv32i_multicycle_core: RTL and testbench

- Multicycle RV32I integer core with a single unified instruction/data memory port.
- Fetches, decodes and executes one instruction at a time over 3–5 clocks, sharing one ALU and one memory interface.
- Memory read is combinational: memReadData reflects memAddress in the same cycle.
- Top-level processing element; the memory model lives outside.

---
 rtl/rv_pkg.sv | 51 +++++
 rtl/rv32i_multicycle_core_alu.sv | 37 +++
 rtl/rv32i_multicycle_core.sv | 155 +++++++++++++++
 tb/tb_rv32i_multicycle_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the multicycle RV32I core: opcodes, FSM states, ALU ops, immediates.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALUWB, MEMADR, MEMREAD,
    MEMWB, MEMWRITE, BRANCH, JAL, JALR, LUI, AUIPC
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  // funct7[5] selects sub only for R-type; for both formats it selects sra on shifts.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic f7b5,
                                         input logic is_r);
    case (funct3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] ir, input imm_t kind);
    case (kind)
      IMM_I:   return {{20{ir[31]}}, ir[31:20]};
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   return {ir[31:12], 12'b0};
      default: return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/rv32i_multicycle_core_alu.sv
// Shared combinational ALU for every datapath step of the multicycle core.
module rv_alu
  import rv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        zero
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'b0, (a_s < b_s)};
      ALU_SLTU: result = {31'b0, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = a_s >>> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rv32i_multicycle_core.sv
// Multicycle RV32I core: one shared ALU, one unified memory port, 3-5 clocks per instruction.
module rv32i_multicycle_core
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memReadData,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite
);

  state_t      state;
  logic [31:0] pc, old_pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_u, imm_j;
  logic [31:0] alu_a, alu_b, alu_res, rf_wd;
  alu_op_t     alu_op;
  logic        alu_zero, taken, rf_we;

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign imm_i   = gen_imm(ir, IMM_I);
  assign imm_s   = gen_imm(ir, IMM_S);
  assign imm_u   = gen_imm(ir, IMM_U);
  assign imm_j   = gen_imm(ir, IMM_J);

  // The single ALU defaults to PC+4, which is exactly what FETCH needs.
  always_comb begin
    alu_a  = pc;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    case (state)
      DECODE: begin alu_a = old_pc; alu_b = gen_imm(ir, IMM_B); end
      EXEC_R: begin alu_a = a; alu_b = b; alu_op = alu_decode(funct3, ir[30], 1'b1); end
      EXEC_I: begin alu_a = a; alu_b = imm_i; alu_op = alu_decode(funct3, ir[30], 1'b0); end
      MEMADR: begin alu_a = a; alu_b = (opcode == OP_STORE) ? imm_s : imm_i; end
      BRANCH: begin
        alu_a  = a;
        alu_b  = b;
        alu_op = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      end
      JAL:    begin alu_a = old_pc; alu_b = imm_j; end
      JALR:   begin alu_a = a; alu_b = imm_i; end
      AUIPC:  begin alu_a = old_pc; alu_b = imm_u; end
      default: ;
    endcase
  end

  rv_alu alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // funct3[0] inverts the sense: beq/bne, blt/bge, bltu/bgeu.
  assign taken = funct3[2] ? (alu_res[0] ^ funct3[0]) : (alu_zero ^ funct3[0]);

  // PC already holds oldPC+4 after FETCH, so it doubles as the link value.
  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_out;
    case (state)
      ALUWB:      rf_we = 1'b1;
      MEMWB:      begin rf_we = 1'b1; rf_wd = mdr; end
      JAL, JALR:  begin rf_we = 1'b1; rf_wd = pc; end
      LUI:        begin rf_we = 1'b1; rf_wd = imm_u; end
      AUIPC:      begin rf_we = 1'b1; rf_wd = alu_res; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      old_pc  <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (rf_we && rd != 5'd0) rf[rd] <= rf_wd;
      case (state)
        FETCH: begin
          ir     <= memReadData;
          old_pc <= pc;
          pc     <= alu_res;
          state  <= DECODE;
        end
        DECODE: begin
          a       <= rs1_val;
          b       <= rs2_val;
          alu_out <= alu_res;
          case (opcode)
            OP_R:               state <= EXEC_R;
            OP_I:               state <= EXEC_I;
            OP_LOAD, OP_STORE:  state <= MEMADR;
            OP_BRANCH:          state <= BRANCH;
            OP_JAL:             state <= JAL;
            OP_JALR:            state <= JALR;
            OP_LUI:             state <= LUI;
            OP_AUIPC:           state <= AUIPC;
            default:            state <= FETCH;
          endcase
        end
        EXEC_R, EXEC_I: begin
          alu_out <= alu_res;
          state   <= ALUWB;
        end
        MEMADR: begin
          alu_out <= alu_res;
          state   <= (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          mdr   <= memReadData;
          state <= MEMWB;
        end
        BRANCH: begin
          if (taken) pc <= alu_out;
          state <= FETCH;
        end
        JAL: begin
          pc    <= alu_res;
          state <= FETCH;
        end
        JALR: begin
          pc    <= alu_res & ~32'd1;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign memAddress   = (state == MEMREAD || state == MEMWRITE) ? alu_out : pc;
  assign memWrite     = (state == MEMWRITE);
  assign memWriteData = b;

endmodule

// File: tb/tb_rv32i_multicycle_core.sv
// Directed program tests for rv32i_multicycle_core against a word-addressed memory model.
module tb_rv32i_multicycle_core;

  localparam logic [31:0] SENT = 32'hDEAD_BE00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memReadData, memAddress, memWriteData;
  logic        memWrite;

  logic [31:0] mem [0:255];
  logic [31:0] addr_log [0:127];
  logic [31:0] wr_addr, wr_data;
  int          checks = 0;
  int          failures = 0;
  int          cyc, wr_count, wr_first;

  rv32i_multicycle_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .memReadData  (memReadData),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memWrite     (memWrite)
  );

  assign memReadData = mem[memAddress[9:2]];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Sample index n is the negedge after n rising edges since reset release.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (cyc < 128) addr_log[cyc] = memAddress;
      if (memWrite) begin
        if (wr_count == 0) wr_first = cyc;
        wr_count++;
        wr_addr = memAddress;
        wr_data = memWriteData;
        mem[memAddress[9:2]] = memWriteData;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic begin_test();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] = SENT;
  endtask

  task automatic release_reset(input string tag);
    check({tag, "_rst_addr"}, memAddress, 32'h0);
    check({tag, "_rst_we"}, {31'b0, memWrite}, 32'h0);
    check({tag, "_rst_wdata"}, memWriteData, 32'h0);
    @(negedge clk);
    reset    = 1'b1;
    cyc      = 0;
    wr_count = 0;
    wr_first = -1;
  endtask

  initial begin
    // Four ADDIs then stores of x10, x1, x2, x3.
    begin_test();
    mem[0] = 32'h00a58513;
    mem[1] = 32'h00000093;
    mem[2] = 32'h00100113;
    mem[3] = 32'h00208193;
    mem[4] = enc_s(12'h080, 5'd10, 5'd0);
    mem[5] = enc_s(12'h084, 5'd1, 5'd0);
    mem[6] = enc_s(12'h088, 5'd2, 5'd0);
    mem[7] = enc_s(12'h08c, 5'd3, 5'd0);
    mem[8] = enc_j(21'd0, 5'd0);
    release_reset("t1");
    run(45);
    check("t1_fetch0", addr_log[0], 32'h0);
    check("t1_fetch1", addr_log[4], 32'h4);
    check("t1_fetch2", addr_log[8], 32'h8);
    check("t1_fetch3", addr_log[12], 32'hc);
    check("t1_first_store_cycle", wr_first, 32'd19);
    check("t1_store_count", wr_count, 32'd4);
    check("t1_x10", mem[32], 32'd10);
    check("t1_x1", mem[33], 32'd0);
    check("t1_x2", mem[34], 32'd1);
    check("t1_x3", mem[35], 32'd2);

    // Single store of 5 to 0x40.
    begin_test();
    mem[0] = addi(5'd1, 5'd0, 12'h040);
    mem[1] = addi(5'd2, 5'd0, 12'h005);
    mem[2] = enc_s(12'h000, 5'd2, 5'd1);
    mem[3] = enc_j(21'd0, 5'd0);
    release_reset("t2");
    run(30);
    check("t2_store_count", wr_count, 32'd1);
    check("t2_store_addr", wr_addr, 32'h40);
    check("t2_store_data", wr_data, 32'd5);
    check("t2_store_cycle", wr_first, 32'd11);

    // Load from 0x40 then store to 0x44.
    begin_test();
    mem[16] = 32'h0000_1234;
    mem[0]  = addi(5'd1, 5'd0, 12'h040);
    mem[1]  = enc_i(12'h000, 5'd1, 3'b010, 5'd3, 7'b0000011);
    mem[2]  = enc_s(12'h004, 5'd3, 5'd1);
    mem[3]  = enc_j(21'd0, 5'd0);
    release_reset("t3");
    run(30);
    check("t3_memread_addr", addr_log[7], 32'h40);
    check("t3_next_fetch", addr_log[9], 32'h8);
    check("t3_store_cycle", wr_first, 32'd12);
    check("t3_store_addr", wr_addr, 32'h44);
    check("t3_store_data", wr_data, 32'h1234);
    check("t3_store_count", wr_count, 32'd1);

    // Taken beq skips one instruction, not-taken bne falls through.
    begin_test();
    mem[0] = addi(5'd5, 5'd0, 12'h003);
    mem[1] = enc_b(13'd8, 5'd5, 5'd5, 3'b000);
    mem[2] = addi(5'd6, 5'd0, 12'h001);
    mem[3] = enc_s(12'h080, 5'd6, 5'd0);
    mem[4] = enc_b(13'd8, 5'd5, 5'd5, 3'b001);
    mem[5] = addi(5'd7, 5'd0, 12'h009);
    mem[6] = enc_s(12'h084, 5'd7, 5'd0);
    mem[7] = enc_j(21'd0, 5'd0);
    release_reset("t4");
    run(40);
    check("t4_beq_target", addr_log[7], 32'hc);
    check("t4_bne_fallthru", addr_log[14], 32'h14);
    check("t4_store_count", wr_count, 32'd2);
    check("t4_skipped_x6", mem[32], 32'd0);
    check("t4_x7", mem[33], 32'd9);

    // jal x1,+16 from 0x10; x0 stays zero.
    begin_test();
    mem[0]  = enc_j(21'd16, 5'd0);
    mem[4]  = enc_j(21'd16, 5'd1);
    mem[5]  = enc_s(12'h090, 5'd0, 5'd0);
    mem[6]  = enc_s(12'h090, 5'd0, 5'd0);
    mem[7]  = enc_s(12'h090, 5'd0, 5'd0);
    mem[8]  = enc_s(12'h080, 5'd1, 5'd0);
    mem[9]  = addi(5'd0, 5'd0, 12'h007);
    mem[10] = enc_s(12'h084, 5'd0, 5'd0);
    mem[11] = enc_j(21'd0, 5'd0);
    release_reset("t5");
    run(40);
    check("t5_jal0_target", addr_log[3], 32'h10);
    check("t5_jal1_target", addr_log[6], 32'h20);
    check("t5_store_count", wr_count, 32'd2);
    check("t5_link", mem[32], 32'h14);
    check("t5_x0", mem[33], 32'h0);

    // Signed/unsigned ALU cases on 0x8000_0000.
    begin_test();
    mem[0]  = {20'h80000, 5'd6, 7'b0110111};
    mem[1]  = addi(5'd5, 5'd0, 12'h003);
    mem[2]  = enc_r(7'b0100000, 5'd5, 5'd6, 3'b101, 5'd7);
    mem[3]  = enc_r(7'b0000000, 5'd5, 5'd6, 3'b101, 5'd8);
    mem[4]  = enc_r(7'b0000000, 5'd5, 5'd6, 3'b010, 5'd9);
    mem[5]  = enc_r(7'b0000000, 5'd5, 5'd6, 3'b011, 5'd11);
    mem[6]  = enc_r(7'b0100000, 5'd6, 5'd5, 3'b000, 5'd12);
    mem[7]  = enc_i(12'h404, 5'd6, 3'b101, 5'd13, 7'b0010011);
    mem[8]  = enc_s(12'h100, 5'd7, 5'd0);
    mem[9]  = enc_s(12'h104, 5'd8, 5'd0);
    mem[10] = enc_s(12'h108, 5'd9, 5'd0);
    mem[11] = enc_s(12'h10c, 5'd11, 5'd0);
    mem[12] = enc_s(12'h110, 5'd12, 5'd0);
    mem[13] = enc_s(12'h114, 5'd13, 5'd0);
    mem[14] = enc_j(21'd0, 5'd0);
    release_reset("t6");
    run(70);
    check("t6_sra", mem[64], 32'hF000_0000);
    check("t6_srl", mem[65], 32'h1000_0000);
    check("t6_slt", mem[66], 32'h1);
    check("t6_sltu", mem[67], 32'h0);
    check("t6_sub", mem[68], 32'h8000_0003);
    check("t6_srai", mem[69], 32'hF800_0000);

    // Reset during MEMADR of a store aborts it.
    begin_test();
    mem[0] = enc_s(12'h080, 5'd0, 5'd0);
    mem[1] = enc_j(21'd0, 5'd0);
    release_reset("t7");
    run(2);
    check("t7_memadr_addr", memAddress, 32'h4);
    reset = 1'b0;
    #1;
    check("t7_async_addr", memAddress, 32'h0);
    check("t7_async_we", {31'b0, memWrite}, 32'h0);
    run(3);
    check("t7_store_count", wr_count, 32'd0);
    check("t7_mem_untouched", mem[32], SENT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
